data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data-memory interface.
- Accepts one load or store request per transaction through a valid/ready handshake.
- Models a fixed access latency, performs the doubleword access on an internal array, and returns the read data or an error.
- Lets the datapath move from an ideal single-cycle memory to a stall-capable memory with a real handshake.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit doublewords stored; must be a power of two.
- LATENCY, 3, cycles from request acceptance to resp_valid assertion; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- req_valid  in  1  requester presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  64  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset: while Reset_L=0, state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- Reset mid-transaction abandons the transaction. A pending store not yet committed (state WAIT) is never written.
- FSM states are IDLE, WAIT and RESP. req_ready is 1 only in IDLE.
- IDLE -> WAIT on a rising edge with req_valid & req_ready:
  - capture req_write, req_addr and req_wdata into holding registers;
  - load counter with LATENCY-1.
- WAIT:
  - if counter != 0, decrement it;
  - if counter == 0, perform the access and go to RESP.
  - With LATENCY=1 the access happens on the first edge after acceptance.
- Access timing: request accepted on edge N; resp_valid rises after edge N+LATENCY.
- Address checks, applied to the captured address:
  - word index = addr[log2(DEPTH_WORDS)+2:3];
  - misaligned if addr[2:0] != 0;
  - out of range if any addr bit above the index field is nonzero.
- On an error: no array write, resp_rdata=0, resp_err=1.
- Store: array[index] <= wdata; resp_rdata=0, resp_err=0.
- Load: resp_rdata = array[index] as of the access edge, resp_err=0.
- RESP: resp_valid=1, and resp_rdata and resp_err hold stable until resp_valid & resp_ready on a rising edge. On that edge go to IDLE, clear resp_valid, and zero resp_rdata/resp_err.
- Back-pressure: in RESP with resp_ready=0, the block stays in RESP indefinitely and req_valid is ignored.
- No pipelining: exactly one outstanding transaction. The minimum transaction period is LATENCY+2 cycles (accept, LATENCY cycles, response handshake, IDLE).
- req_* inputs are ignored outside the acceptance edge; changing them during WAIT or RESP has no effect.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the doubleword byte-offset width constant (3);
  - the index-width function clog2(DEPTH_WORDS).
- One natural sub-module, data_mem_array: a single-port DEPTH_WORDS x 64 synchronous array with a write enable, an index input, wdata, and a combinational read. The FSM, counter, holding registers and range check stay in data_mem_responder.

Test Plan:
- Store then load, LATENCY=3: store addr 0x10 data 0xDEADBEEFCAFEF00D, then load 0x10.
  - Each resp_valid rises 3 cycles after acceptance.
  - Load returns 0xDEADBEEFCAFEF00D, resp_err=0.
  - Store response has rdata=0.
- Misaligned access: store to 0x13 -> resp_err=1, rdata=0. A following load of 0x10 still returns the prior value, proving the array was unmodified.
- Out of range, DEPTH_WORDS=256: load 0x800 -> resp_err=1, rdata=0.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid rises.
  - resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0.
  - A req_valid pulse during this window is not accepted.
  - Releasing resp_ready gives IDLE on the next cycle.
- Reset mid-operation: assert Reset_L=0 one cycle after accepting a store of 0x1111 to 0x20.
  - All outputs go to reset values immediately.
  - A later load of 0x20 returns the pre-store value.
- LATENCY=1: back-to-back loads with resp_ready tied 1.
  - resp_valid asserts 1 cycle after each acceptance.
  - Acceptances are spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths
// and the index-width helper used to size the doubleword array.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } respState_e;

    localparam int unsigned BYTE_OFF_W = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;

    // Ceiling log2; clog2(1) is 0, callers keep DEPTH_WORDS >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem != 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the datapath (master) and the data-memory
// responder (slave); both directions use valid/ready handshakes.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port doubleword store: synchronous write, combinational read of the
// addressed word. Contents are deliberately not reset.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = clog2(DEPTH_WORDS)
) (
    input  logic              CLK,
    input  logic              writeEn,
    input  logic [IDX_W-1:0]  wordIdx,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] memArray [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (writeEn) begin
            memArray[wordIdx] <= writeData;
        end
    end

    assign readData = memArray[wordIdx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// latency, accesses the array, then holds the response until it is consumed.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic               CLK,
    input  logic               Reset_L,
    data_mem_responder_if.slave memIf
);

    localparam int unsigned      IDX_W    = clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    respState_e        stateReg, stateNext;
    logic [CNT_W-1:0]  cntReg, cntNext;
    logic              holdWriteReg, holdWriteNext;
    logic [ADDR_W-1:0] holdAddrReg, holdAddrNext;
    logic [DATA_W-1:0] holdWdataReg, holdWdataNext;
    logic [DATA_W-1:0] respRdataReg, respRdataNext;
    logic              respErrReg, respErrNext;

    logic [IDX_W-1:0]  wordIdx;
    logic [ADDR_W-1:0] highBits;
    logic              accessErr;
    logic              memWe;
    logic [DATA_W-1:0] memRdata;

    assign wordIdx = holdAddrReg[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

    // Keep only the address bits above the index field; any of them set
    // means the request points past the end of the array.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_high
            if (gi >= IDX_W + BYTE_OFF_W) begin : g_chk
                assign highBits[gi] = holdAddrReg[gi];
            end else begin : g_idx
                assign highBits[gi] = 1'b0;
            end
        end
    endgenerate

    assign accessErr = (|holdAddrReg[BYTE_OFF_W-1:0]) | (|highBits);

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .CLK       (CLK),
        .writeEn   (memWe),
        .wordIdx   (wordIdx),
        .writeData (holdWdataReg),
        .readData  (memRdata)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            holdWriteReg <= 1'b0;
            holdAddrReg  <= '0;
            holdWdataReg <= '0;
            respRdataReg <= '0;
            respErrReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            holdWriteReg <= holdWriteNext;
            holdAddrReg  <= holdAddrNext;
            holdWdataReg <= holdWdataNext;
            respRdataReg <= respRdataNext;
            respErrReg   <= respErrNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        cntNext       = cntReg;
        holdWriteNext = holdWriteReg;
        holdAddrNext  = holdAddrReg;
        holdWdataNext = holdWdataReg;
        respRdataNext = respRdataReg;
        respErrNext   = respErrReg;
        memWe         = 1'b0;

        case (stateReg)
            IDLE: begin
                if (memIf.req_valid) begin
                    holdWriteNext = memIf.req_write;
                    holdAddrNext  = memIf.req_addr;
                    holdWdataNext = memIf.req_wdata;
                    cntNext       = CNT_LOAD;
                    stateNext     = WAIT;
                end
            end
            WAIT: begin
                if (cntReg != '0) begin
                    cntNext = cntReg - CNT_W'(1);
                end else begin
                    // Access edge: errors suppress the write and return zero data.
                    stateNext = RESP;
                    if (accessErr) begin
                        respRdataNext = '0;
                        respErrNext   = 1'b1;
                    end else if (holdWriteReg) begin
                        memWe         = 1'b1;
                        respRdataNext = '0;
                        respErrNext   = 1'b0;
                    end else begin
                        respRdataNext = memRdata;
                        respErrNext   = 1'b0;
                    end
                end
            end
            RESP: begin
                if (memIf.resp_ready) begin
                    stateNext     = IDLE;
                    respRdataNext = '0;
                    respErrNext   = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign memIf.req_ready  = (stateReg == IDLE);
    assign memIf.resp_valid = (stateReg == RESP);
    assign memIf.resp_rdata = respRdataReg;
    assign memIf.resp_err   = respErrReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: a timestamp-based transaction model checks
// every cycle of a LATENCY=3 instance; a LATENCY=1 instance checks throughput.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic clk  = 1'b0;
    logic rstA = 1'b0;
    logic rstB = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if ifA ();
    data_mem_responder_if ifB ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dutA (
        .CLK(clk), .Reset_L(rstA), .memIf(ifA)
    );
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dutB (
        .CLK(clk), .Reset_L(rstB), .memIf(ifB)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit isErr(input logic [63:0] a);
        return (a % 64'd8 != 64'd0) || (a >= 64'(DEPTH * 8));
    endfunction

    // Transaction-level model: one outstanding request, response becomes
    // visible LAT_A edges after acceptance and retires on a handshake edge.
    logic [63:0] refMem [DEPTH];
    bit          busy = 1'b0;
    int          accEdge = 0;
    int          nAcc = 0;
    bit          pendWrite;
    logic [63:0] pendAddr, pendWdata;
    logic [63:0] expRdata = '0;
    bit          expErr = 1'b0;

    always @(posedge clk or negedge rstA) begin : model
        int e;
        if (!rstA) begin
            busy = 1'b0;
        end else begin
            e = cyc + 1;
            if (busy) begin
                if (e == accEdge + LAT_A) begin
                    expErr = isErr(pendAddr);
                    if (expErr) expRdata = '0;
                    else if (pendWrite) begin
                        refMem[pendAddr / 8] = pendWdata;
                        expRdata = '0;
                    end else expRdata = refMem[pendAddr / 8];
                end else if (e > accEdge + LAT_A && ifA.resp_ready) begin
                    busy = 1'b0;
                end
            end else if (ifA.req_valid) begin
                busy      = 1'b1;
                accEdge   = e;
                pendWrite = ifA.req_write;
                pendAddr  = ifA.req_addr;
                pendWdata = ifA.req_wdata;
                nAcc++;
            end
        end
    end

    always @(negedge clk) begin : compareA
        bit expValid;
        expValid = busy && (cyc >= accEdge + LAT_A);
        check64("req_ready", 64'(ifA.req_ready), 64'(!busy));
        check64("resp_valid", 64'(ifA.resp_valid), 64'(expValid));
        check64("resp_rdata", ifA.resp_rdata, expValid ? expRdata : 64'd0);
        check64("resp_err", 64'(ifA.resp_err), 64'(expValid && expErr));
    end

    // bp < 0: random resp_ready; bp >= 0: hold resp_ready low bp cycles after resp_valid.
    task automatic doTxn(input bit w, input logic [63:0] a, input logic [63:0] d,
                         input int bp, input bit pulse,
                         output int lat, output logic [63:0] capR, output logic capE);
        int n;
        int startAcc;
        int accE;
        int holdLeft;
        bit seen;
        lat  = -1;
        capR = 'x;
        capE = 1'bx;
        @(posedge clk); #1;
        ifA.req_valid  = 1'b1;
        ifA.req_write  = w;
        ifA.req_addr   = a;
        ifA.req_wdata  = d;
        ifA.resp_ready = 1'b0;
        startAcc = nAcc;
        n = 0;
        while (nAcc == startAcc && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        accE = cyc;
        ifA.req_valid = 1'b0;
        ifA.req_write = 1'($urandom);
        ifA.req_addr  = {$urandom(), $urandom()};
        ifA.req_wdata = {$urandom(), $urandom()};
        seen = 1'b0;
        holdLeft = bp;
        n = 0;
        while (n < 200) begin
            if (bp < 0) ifA.resp_ready = 1'($urandom);
            else if (!seen) ifA.resp_ready = 1'b0;
            else if (holdLeft > 0) begin
                ifA.resp_ready = 1'b0;
                ifA.req_valid  = pulse && (holdLeft == 3);
                ifA.req_write  = 1'b1;
                ifA.req_addr   = a;
                holdLeft--;
            end else begin
                ifA.resp_ready = 1'b1;
                ifA.req_valid  = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (!seen && ifA.resp_valid) begin
                seen = 1'b1;
                lat  = cyc - accE;
                capR = ifA.resp_rdata;
                capE = ifA.resp_err;
            end
            if (!busy) break;
        end
        ifA.req_valid  = 1'b0;
        ifA.resp_ready = 1'b0;
        if (n >= 200 || !seen) begin
            errors++;
            $display("FAIL txn_timeout addr=%h seen=%0d required response", a, seen);
        end
        $display("txn %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 w ? "ST" : "LD", a, d, capR, capE, lat);
    endtask

    // LATENCY=1 instance: req_valid held high, resp_ready tied high.
    bit          bActive = 1'b0;
    int          bLastAcc = -100;
    int          bAccCount = 0;
    int          bRespCount = 0;
    logic [63:0] bVal = 64'h0123_4567_89AB_CDEF;

    always @(negedge clk) begin : monitorB
        if (bActive) begin
            check64("b_resp_valid", 64'(ifB.resp_valid), 64'(cyc == bLastAcc + LAT_B));
            if (ifB.resp_valid) begin
                check64("b_rdata", ifB.resp_rdata, (bRespCount == 0) ? 64'd0 : bVal);
                check64("b_err", 64'(ifB.resp_err), 64'd0);
                bRespCount++;
            end
            if (ifB.req_valid && ifB.req_ready) begin
                if (bAccCount > 0) check64("b_accept_spacing", 64'(cyc + 1 - bLastAcc), 64'd3);
                bLastAcc = cyc + 1;
                bAccCount++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] initVals [DEPTH];
        int          lat;
        logic [63:0] r;
        logic        e;
        logic [63:0] a;
        int          accBefore;
        int          k;

        ifA.req_valid = 1'b0; ifA.req_write = 1'b0; ifA.req_addr = '0;
        ifA.req_wdata = '0;   ifA.resp_ready = 1'b0;
        ifB.req_valid = 1'b0; ifB.req_write = 1'b0; ifB.req_addr = '0;
        ifB.req_wdata = '0;   ifB.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check64("reset_req_ready", 64'(ifA.req_ready), 64'd1);
        check64("reset_resp_valid", 64'(ifA.resp_valid), 64'd0);
        check64("reset_rdata", ifA.resp_rdata, 64'd0);
        rstA = 1'b1;
        rstB = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            initVals[i] = {$urandom(), $urandom()};
            doTxn(1'b1, 64'(i * 8), initVals[i], 0, 1'b0, lat, r, e);
        end

        doTxn(1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 0, 1'b0, lat, r, e);
        check64("store_latency", 64'(lat), 64'd3);
        check64("store_rdata", r, 64'd0);
        check64("store_err", 64'(e), 64'd0);
        doTxn(1'b0, 64'h10, 64'd0, 0, 1'b0, lat, r, e);
        check64("load_latency", 64'(lat), 64'd3);
        check64("load_rdata", r, 64'hDEADBEEFCAFEF00D);
        check64("load_err", 64'(e), 64'd0);

        doTxn(1'b1, 64'h13, 64'h5555_5555_5555_5555, 0, 1'b0, lat, r, e);
        check64("misaligned_err", 64'(e), 64'd1);
        check64("misaligned_rdata", r, 64'd0);
        doTxn(1'b0, 64'h10, 64'd0, 0, 1'b0, lat, r, e);
        check64("after_misaligned_rdata", r, 64'hDEADBEEFCAFEF00D);

        doTxn(1'b0, 64'h800, 64'd0, 0, 1'b0, lat, r, e);
        check64("range_err", 64'(e), 64'd1);
        check64("range_rdata", r, 64'd0);

        accBefore = nAcc;
        doTxn(1'b0, 64'h10, 64'd0, 5, 1'b1, lat, r, e);
        check64("bp_rdata", r, 64'hDEADBEEFCAFEF00D);
        check64("bp_idle_after_release", 64'(ifA.req_ready), 64'd1);
        check64("bp_single_accept", 64'(nAcc - accBefore), 64'd1);
        doTxn(1'b0, 64'h10, 64'd0, 0, 1'b0, lat, r, e);
        check64("bp_pulse_no_write", r, 64'hDEADBEEFCAFEF00D);

        @(posedge clk); #1;
        accBefore = nAcc;
        ifA.req_valid = 1'b1; ifA.req_write = 1'b1;
        ifA.req_addr = 64'h20; ifA.req_wdata = 64'h1111;
        @(posedge clk); #1;
        ifA.req_valid = 1'b0;
        check64("rst_store_accepted", 64'(ifA.req_ready), 64'd0);
        @(posedge clk); #1;
        rstA = 1'b0;
        #1;
        check64("midrst_req_ready", 64'(ifA.req_ready), 64'd1);
        check64("midrst_resp_valid", 64'(ifA.resp_valid), 64'd0);
        check64("midrst_rdata", ifA.resp_rdata, 64'd0);
        check64("midrst_err", 64'(ifA.resp_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstA = 1'b1;
        doTxn(1'b0, 64'h20, 64'd0, 0, 1'b0, lat, r, e);
        check64("midrst_no_commit", r, initVals[4]);

        for (int t = 0; t < 200; t++) begin
            k = int'($urandom_range(0, 9));
            a = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
            if (k == 7 || k == 9) a = a | 64'($urandom_range(1, 7));
            if (k == 8 || k == 9) a = a | (64'd1 << $urandom_range(11, 63));
            doTxn(1'($urandom), a, {$urandom(), $urandom()}, -1, 1'b0, lat, r, e);
        end

        @(posedge clk); #1;
        bActive = 1'b1;
        ifB.req_valid = 1'b1; ifB.req_write = 1'b1;
        ifB.req_addr = 64'h8; ifB.req_wdata = bVal;
        @(posedge clk); #1;
        ifB.req_write = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        ifB.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bActive = 1'b0;
        check64("b_accept_count_ok", 64'(bAccCount >= 5), 64'd1);
        check64("b_resp_count_ok", 64'(bRespCount == bAccCount), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
